// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state encodings for the sequential ALU.
// Also holds the helper that classifies multi-cycle opcodes.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_MUL   = 4'h2;
  localparam logic [3:0] OP_DIV   = 4'h3;
  localparam logic [3:0] OP_MOD   = 4'h4;
  localparam logic [3:0] OP_PASSB = 4'h5;
  localparam logic [3:0] OP_POW   = 4'h6;
  localparam logic [3:0] OP_NEG   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h8;
  localparam logic [3:0] OP_AND   = 4'h9;
  localparam logic [3:0] OP_XOR   = 4'hA;
  localparam logic [3:0] OP_GT    = 4'hB;
  localparam logic [3:0] OP_EQ    = 4'hC;
  localparam logic [3:0] OP_SHL   = 4'hD;
  localparam logic [3:0] OP_SHR   = 4'hE;
  localparam logic [3:0] OP_PASSA = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Opcodes that occupy the fixed WIDTH+1 cycle iterative path.
  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD) || (op == OP_POW);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between decoder, ALU and writeback.
interface alu_seq_if #(parameter int WIDTH = 32) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_dz;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_dz
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_dz
  );
endinterface

// File: rtl/alu_seq_divider.sv
// Iterative signed restoring divider: magnitudes divided over WIDTH cycles,
// quotient/remainder signs fixed up on the outputs.
module alu_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             done_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q, qneg_q, rneg_q;

  logic [WIDTH-1:0] ua, ub, rem_d, quo_d;
  logic [WIDTH:0]   rem_sh, diff;

  assign ua = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
  assign ub = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;

  // Shift next dividend bit into the partial remainder; borrow bit decides restore.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, div_q};
    quo_d  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    rem_d  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= ua;
      div_q  <= ub;
      cnt_q  <= CW'(WIDTH);
      run_q  <= 1'b1;
      qneg_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      rneg_q <= a_i[WIDTH-1];
    end else if (run_q) begin
      if (cnt_q != '0) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - CW'(1);
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign quo_o  = qneg_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_o  = rneg_q ? (~rem_q + 1'b1) : rem_q;
  assign done_o = run_q && (cnt_q == '0);
endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle ops finish one cycle after accept,
// DIV/MOD/POW run a fixed WIDTH+1 cycles. One op in flight at a time.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d, base_q, base_d, exp_q, exp_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d, dz_q, dz_d;

  logic             accept, pow_step, fin, dz_fin;
  logic [WIDTH-1:0] div_quo, div_rem, mul_x, mul_y, mul_p, sq_p, alu_res, y_fin;
  logic             div_done;

  assign accept = (state_q == ST_IDLE) && bus.in_valid;

  alu_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept),
    .a_i     (bus.in_a),
    .b_i     (bus.in_b),
    .quo_o   (div_quo),
    .rem_o   (div_rem),
    .done_o  (div_done)
  );

  // The MUL multiplier doubles as the POW accumulate multiplier.
  assign pow_step = (state_q == ST_BUSY) && (op_q == OP_POW);
  assign mul_x    = pow_step ? acc_q  : a_q;
  assign mul_y    = pow_step ? base_q : b_q;
  assign mul_p    = mul_x * mul_y;
  assign sq_p     = base_q * base_q;

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:   alu_res = a_q + b_q;
      OP_SUB:   alu_res = a_q - b_q;
      OP_MUL:   alu_res = mul_p;
      OP_PASSB: alu_res = b_q;
      OP_NEG:   alu_res = ~a_q + 1'b1;
      OP_OR:    alu_res = a_q | b_q;
      OP_AND:   alu_res = a_q & b_q;
      OP_XOR:   alu_res = a_q ^ b_q;
      OP_GT:    alu_res = WIDTH'($signed(a_q) > $signed(b_q));
      OP_EQ:    alu_res = WIDTH'(a_q == b_q);
      OP_SHL:   alu_res = (b_q >= W_LIM) ? '0 : (a_q << b_q[SHW-1:0]);
      OP_SHR:   alu_res = (b_q >= W_LIM) ? '0 : (a_q >> b_q[SHW-1:0]);
      OP_PASSA: alu_res = a_q;
      default:  alu_res = '0;
    endcase
  end

  // Exceptional DIV/MOD/POW results override the iterative outcome at completion.
  always_comb begin
    dz_fin = 1'b0;
    y_fin  = alu_res;
    case (op_q)
      OP_DIV: begin
        dz_fin = (b_q == '0);
        y_fin  = dz_fin ? '1 : div_quo;
      end
      OP_MOD: begin
        dz_fin = (b_q == '0);
        y_fin  = dz_fin ? a_q : div_rem;
      end
      OP_POW: begin
        dz_fin = b_q[WIDTH-1];
        y_fin  = dz_fin ? '0 : acc_q;
      end
      default: ;
    endcase
  end

  assign fin = ((op_q == OP_DIV) || (op_q == OP_MOD)) ? div_done : (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    y_d     = y_q;
    zero_d  = zero_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    base_d  = base_q;
    exp_d   = exp_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        a_d     = bus.in_a;
        b_d     = bus.in_b;
        op_d    = bus.in_op;
        cnt_d   = is_iter(bus.in_op) ? CW'(WIDTH) : '0;
        acc_d   = WIDTH'(1);
        base_d  = bus.in_a;
        exp_d   = bus.in_b;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (fin) begin
          state_d = ST_DONE;
          y_d     = y_fin;
          dz_d    = dz_fin;
          zero_d  = (y_fin == '0);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (pow_step) begin
            if (exp_q[0]) acc_d = mul_p;
            base_d = sq_p;
            exp_d  = exp_q >> 1;
          end
        end
      end
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      y_q     <= '0;
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_y     = y_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_dz    = dz_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32) with queue-based scoreboard.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] y;
    logic         dz;
    int           lat;
    int           acc;
    string        nm;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: a result is consumed on each negedge that shows valid & ready.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious out_valid", W'(bus.out_valid), W'(0));
      end else begin
        e = sb.pop_front();
        chk({e.nm, " y"}, bus.out_y, e.y);
        chk({e.nm, " zero"}, W'(bus.out_zero), W'(e.y == '0));
        chk({e.nm, " dz"}, W'(bus.out_dz), W'(e.dz));
        if (e.lat > 0) chk({e.nm, " latency"}, W'(cyc - e.acc), W'(e.lat));
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] y, input logic dz, input bit lat_chk, input bit push);
    exp_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk("in_ready timeout", W'(bus.in_ready), W'(1));
      return;
    end
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble operands right after accept; the result must not depend on them.
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    bus.in_op    = ~op;
    if (push) begin
      e.y   = y;
      e.dz  = dz;
      e.lat = lat_chk ? (is_iter(op) ? W + 1 : 1) : 0;
      e.acc = cyc;
      e.nm  = $sformatf("op%0h a=%h b=%h", op, a, b);
      sb.push_back(e);
    end
  endtask

  task automatic v(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                   input logic [W-1:0] y, input logic dz);
    send(op, a, b, y, dz, 1'b1, 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) chk("drain timeout", W'(sb.size()), W'(0));
  endtask

  initial begin
    int t;
    int nv;
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'h1;
    bus.in_b      = 32'h1;
    bus.in_op     = OP_ADD;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", W'(bus.out_valid), W'(0));
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    chk("reset in_ready", W'(bus.in_ready), W'(1));
    chk("reset out_y", bus.out_y, 32'h0);
    chk("reset out_zero", W'(bus.out_zero), W'(0));
    chk("reset out_dz", W'(bus.out_dz), W'(0));

    v(OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
    v(OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
    v(OP_MUL,   32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 1'b0);
    v(OP_MUL,   32'h00010000, 32'h00010000, 32'h00000000, 1'b0);
    v(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0);
    v(OP_MOD,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0);
    v(OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
    v(OP_MOD,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    v(OP_DIV,   32'h00000064, 32'h00000007, 32'h0000000E, 1'b0);
    v(OP_MOD,   32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 1'b0);
    v(OP_DIV,   32'h00000009, 32'h00000000, 32'hFFFFFFFF, 1'b1);
    v(OP_MOD,   32'h00000009, 32'h00000000, 32'h00000009, 1'b1);
    v(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    v(OP_MOD,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    v(OP_POW,   32'h00000003, 32'h00000005, 32'h000000F3, 1'b0);
    v(OP_POW,   32'h00000002, 32'h00000020, 32'h00000000, 1'b0);
    v(OP_POW,   32'h00000007, 32'h00000000, 32'h00000001, 1'b0);
    v(OP_POW,   32'h00000000, 32'h00000000, 32'h00000001, 1'b0);
    v(OP_POW,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFF8, 1'b0);
    v(OP_POW,   32'h00000002, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    v(OP_SHL,   32'h00000001, 32'h0000001F, 32'h80000000, 1'b0);
    v(OP_SHL,   32'h00000001, 32'h00000020, 32'h00000000, 1'b0);
    v(OP_SHR,   32'hFFFFFFFF, 32'h0000001C, 32'h0000000F, 1'b0);
    v(OP_SHR,   32'h80000000, 32'h0000001F, 32'h00000001, 1'b0);
    v(OP_SHR,   32'hFFFFFFFF, 32'h00000064, 32'h00000000, 1'b0);
    v(OP_GT,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    v(OP_GT,    32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    v(OP_EQ,    32'h00000004, 32'h00000004, 32'h00000001, 1'b0);
    v(OP_EQ,    32'h00000004, 32'h00000005, 32'h00000000, 1'b0);
    v(OP_NEG,   32'h00000005, 32'h00000000, 32'hFFFFFFFB, 1'b0);
    v(OP_OR,    32'h000000F0, 32'h0000003C, 32'h000000FC, 1'b0);
    v(OP_AND,   32'h000000F0, 32'h0000003C, 32'h00000030, 1'b0);
    v(OP_XOR,   32'h000000F0, 32'h0000003C, 32'h000000CC, 1'b0);
    v(OP_PASSB, 32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 1'b0);
    v(OP_PASSA, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 1'b0);
    drain();

    // Backpressure: result must hold and new requests must be ignored.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(OP_ADD, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0, 1'b1);
    t = 0;
    while (!bus.out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    repeat (10) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 32'd55;
      bus.in_b     = 32'd1;
      bus.in_op    = OP_SUB;
      chk("stall out_y", bus.out_y, 32'h7);
      chk("stall out_valid", W'(bus.out_valid), W'(1));
      chk("stall in_ready", W'(bus.in_ready), W'(0));
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset mid-DIV: the aborted op must never produce a result.
    send(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
    end
    chk("abort out_valid count", W'(nv), W'(0));
    chk("abort in_ready", W'(bus.in_ready), W'(1));

    v(OP_ADD, 32'h2, 32'h2, 32'h4, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
